// File: rtl/factor_sweep_pkg.sv
// Shared definitions for the factor_sweep operand generator.
// Configuration macro: SWEEP_TRIANGLE_EN selects the a<b triangle sweep;
// when undefined the full a/b square is swept.
package factor_sweep_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_t;

    // Default operand width; must match the product checker's a/b width.
    localparam int DEFAULT_WIDTH = 4;

`ifdef SWEEP_TRIANGLE_EN
    localparam bit TRIANGLE_MODE = 1'b1;
`else
    localparam bit TRIANGLE_MODE = 1'b0;
`endif

    // Number of (a, b) pairs one complete sweep presents.
    function automatic int unsigned pair_count(input int unsigned width,
                                               input bit          triangle);
        if (triangle) begin
            return (32'd1 << (width - 1)) * ((32'd1 << width) - 32'd1);
        end
        return 32'd1 << (2 * width);
    endfunction

endpackage

// File: rtl/factor_sweep_pair_counter.sv
// Nested a/b operand counter: a is the outer loop, b the inner loop.
// In triangle mode (SWEEP_TRIANGLE_EN) each inner loop restarts at a+1,
// otherwise at 0. o_last flags the final pair so the controller never
// advances past it.
module sweep_pair_counter
    import factor_sweep_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_advance,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_last
);

    localparam logic [WIDTH-1:0] MAX_V  = '1;
    localparam logic [WIDTH-1:0] ZERO_V = '0;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_inc;
    logic [WIDTH-1:0] w_first_b_load;
    logic [WIDTH-1:0] w_first_b_wrap;
    logic             w_b_at_max;

    // Next-pair helpers: first b of the next row, and first b after a load.
    always_comb begin
        w_a_inc    = r_a + WIDTH'(1);
        w_b_at_max = (r_b == MAX_V);
        if (TRIANGLE_MODE) begin
            w_first_b_load = WIDTH'(1);
            w_first_b_wrap = w_a_inc + WIDTH'(1);
            o_last         = (r_a == (MAX_V - WIDTH'(1))) && w_b_at_max;
        end else begin
            w_first_b_load = ZERO_V;
            w_first_b_wrap = ZERO_V;
            o_last         = (r_a == MAX_V) && w_b_at_max;
        end
    end

    // Operand registers: load restarts the sweep, advance steps one pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load) begin
            r_a <= ZERO_V;
            r_b <= w_first_b_load;
        end else if (i_advance) begin
            if (w_b_at_max) begin
                r_a <= w_a_inc;
                r_b <= w_first_b_wrap;
            end else begin
                r_b <= r_b + WIDTH'(1);
            end
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;

endmodule

// File: rtl/factor_sweep.sv
// factor_sweep: walks operand pairs into a combinational product checker,
// one pair per clock, and stops on the first accepted pair or after the
// last pair. Results are held until the next start.
// Configuration macro: SWEEP_TRIANGLE_EN (see factor_sweep_pkg).
//
// Handshake: start is a level sampled on a rising edge only in IDLE/DONE;
// stop is sampled only in SCAN and beats res in the same cycle; res is the
// checker verdict for the a/b currently on the outputs. done is a
// single-cycle pulse, found/a_hit/b_hit/tried hold until the next start.
module factor_sweep
    import factor_sweep_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    input  logic                 res,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [WIDTH-1:0]     a_hit,
    output logic [WIDTH-1:0]     b_hit,
    output logic [2*WIDTH:0]     tried,
    output sweep_state_t         o_state
);

    localparam int TW = 2 * WIDTH + 1;

    sweep_state_t     r_state;
    sweep_state_t     w_state_next;

    logic             w_load;
    logic             w_advance;
    logic             w_scan;
    logic             w_hit;
    logic             w_end;
    logic             w_last;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    logic             r_done;
    logic             r_found;
    logic [WIDTH-1:0] r_a_hit;
    logic [WIDTH-1:0] r_b_hit;
    logic [TW-1:0]    r_tried;

    sweep_pair_counter #(
        .WIDTH (WIDTH)
    ) u_pair_counter (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_advance (w_advance),
        .o_a       (w_a),
        .o_b       (w_b),
        .o_last    (w_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: stop wins over a hit, a hit or the last pair ends SCAN.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_state_next = ST_SCAN;
            ST_SCAN: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (res || w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: if (start) w_state_next = ST_SCAN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the current state and inputs.
    always_comb begin
        w_scan    = (r_state == ST_SCAN);
        w_load    = !w_scan && start;
        w_advance = w_scan && !stop && !res && !w_last;
        w_hit     = w_scan && !stop && res;
        w_end     = w_scan && !stop && (res || w_last);
    end

    // Result capture: cleared on start, counted and latched during SCAN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_found <= 1'b0;
            r_a_hit <= '0;
            r_b_hit <= '0;
            r_tried <= '0;
        end else begin
            r_done <= w_end;
            if (w_load) begin
                r_found <= 1'b0;
                r_a_hit <= '0;
                r_b_hit <= '0;
                r_tried <= '0;
            end else if (w_scan) begin
                r_tried <= r_tried + TW'(1);
                if (w_hit) begin
                    r_found <= 1'b1;
                    r_a_hit <= w_a;
                    r_b_hit <= w_b;
                end
            end
        end
    end

    assign a       = w_a;
    assign b       = w_b;
    assign busy    = w_scan;
    assign done    = r_done;
    assign found   = r_found;
    assign a_hit   = r_a_hit;
    assign b_hit   = r_b_hit;
    assign tried   = r_tried;
    assign o_state = r_state;

endmodule

// File: tb/tb_factor_sweep.sv
// Bench for factor_sweep: table of sweeps (fixed + randomized) checked
// against a nested-loop reference model, plus a mid-sweep reset sequence.
module tb_factor_sweep;
    import factor_sweep_pkg::*;

    localparam int W = 4;
    localparam int N = 1 << W;
    localparam int NV = 12;

`ifdef SWEEP_TRIANGLE_EN
    localparam bit TRI = 1'b1;
`else
    localparam bit TRI = 1'b0;
`endif

    typedef struct {
        int target;
        bit en;
        int stop_cyc;
        bit spam;
        bit e_done;
        bit e_found;
        int e_a;
        int e_b;
        int e_tried;
        int e_last_a;
        int e_last_b;
    } vec_t;

    logic clk, rst, start, stop, res, busy, done, found;
    logic [W-1:0] a, b, a_hit, b_hit;
    logic [2*W:0] tried;
    sweep_state_t dbg_state;

    int  target;
    bit  chk_en;
    bit  force_res;
    int  checks;
    int  errors;
    vec_t vecs[NV];

    factor_sweep #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .a(a), .b(b), .res(res), .busy(busy), .done(done),
        .found(found), .a_hit(a_hit), .b_hit(b_hit), .tried(tried),
        .o_state(dbg_state)
    );

    // Product checker stand-in.
    assign res = force_res || (chk_en && ((int'(a) * int'(b)) == target));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: walk the pair order directly.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int cyc = 0;
        r.e_found = 0; r.e_a = 0; r.e_b = 0; r.e_done = 1;
        r.e_tried = 0; r.e_last_a = 0; r.e_last_b = 0;
        for (int ia = 0; ia < N; ia++) begin
            for (int ib = (TRI ? ia + 1 : 0); ib < N; ib++) begin
                cyc++;
                r.e_last_a = ia; r.e_last_b = ib; r.e_tried = cyc;
                if (v.stop_cyc == cyc) begin
                    r.e_done = 0;
                    return r;
                end
                if (v.en && ia * ib == v.target) begin
                    r.e_found = 1; r.e_a = ia; r.e_b = ib;
                    return r;
                end
            end
        end
        return r;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_a"}, int'(a), 0);
        chk({tag, "_b"}, int'(b), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_found"}, int'(found), 0);
        chk({tag, "_a_hit"}, int'(a_hit), 0);
        chk({tag, "_b_hit"}, int'(b_hit), 0);
        chk({tag, "_tried"}, int'(tried), 0);
        chk({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int scan = 0;
        int dones = 0;
        int last_a = -1;
        int last_b = -1;
        bit ended = 0;
        bit end_done = 0;
        string t;
        t = $sformatf("v%0d", idx);
        target = v.target;
        chk_en = v.en;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 600 && !ended; c++) begin
            if (busy) begin
                scan++;
                if (done) dones++;
                last_a = int'(a); last_b = int'(b);
                if (scan == 1) begin
                    chk({t, "_first_a"}, int'(a), 0);
                    chk({t, "_first_b"}, int'(b), TRI ? 1 : 0);
                end
                stop = (scan == v.stop_cyc);
                force_res = (scan == v.stop_cyc);
                start = v.spam && (scan % 7 == 3);
                @(negedge clk);
            end else begin
                ended = 1;
                end_done = done;
                stop = 1'b0; force_res = 1'b0; start = 1'b0;
            end
        end
        if (!ended) begin
            chk({t, "_timeout"}, 1, 0);
            stop = 1'b0; force_res = 1'b0; start = 1'b0;
            return;
        end
        chk({t, "_scan_cycles"}, scan, v.e_tried);
        chk({t, "_done_pulse"}, int'(end_done), int'(v.e_done));
        chk({t, "_early_done"}, dones, 0);
        chk({t, "_found"}, int'(found), int'(v.e_found));
        chk({t, "_a_hit"}, int'(a_hit), v.e_a);
        chk({t, "_b_hit"}, int'(b_hit), v.e_b);
        chk({t, "_tried"}, int'(tried), v.e_tried);
        chk({t, "_last_a"}, last_a, v.e_last_a);
        chk({t, "_last_b"}, last_b, v.e_last_b);
        chk({t, "_hold_a"}, int'(a), v.e_last_a);
        chk({t, "_hold_b"}, int'(b), v.e_last_b);
        chk({t, "_state"}, int'(dbg_state), v.e_done ? int'(ST_DONE) : int'(ST_IDLE));
        @(negedge clk);
        chk({t, "_done_drop"}, int'(done), 0);
        chk({t, "_found_hold"}, int'(found), int'(v.e_found));
        chk({t, "_tried_hold"}, int'(tried), v.e_tried);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        force_res = 1'b0; chk_en = 1'b0; target = 0;

        // Fixed vectors with hand-derived expectations.
        // 0: real checker, target 143 -> 11*13.
        vecs[0] = '{143, 1, 0, 0, 1, 1, 11, 13, TRI ? 112 : 190, 11, 13};
        // 1: checker never accepts -> exhaustion.
        vecs[1] = '{0, 0, 0, 0, 1, 0, 0, 0,
                    int'(pair_count(W, TRI)), TRI ? 14 : 15, 15};
        // 2: stop on cycle 50 together with res=1.
        vecs[2] = '{143, 1, 50, 0, 0, 0, 0, 0, 50, 3, TRI ? 11 : 1};
        // 3: start hammered during SCAN, same result as vector 0.
        vecs[3] = '{143, 1, 0, 1, 1, 1, 11, 13, TRI ? 112 : 190, 11, 13};
        // 4: product 0 hits on the very first pair.
        vecs[4] = '{0, 1, 0, 0, 1, 1, 0, TRI ? 1 : 0, 1, 0, TRI ? 1 : 0};
        // 5: stop on the first SCAN cycle.
        vecs[5] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, TRI ? 1 : 0};

        // Randomized vectors, expectations from the reference model.
        for (int i = 6; i < NV; i++) begin
            vec_t v;
            v.target   = int'($urandom_range(0, N - 1)) * int'($urandom_range(0, N - 1));
            v.en       = 1'b1;
            v.stop_cyc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 100)) : 0;
            v.spam     = 1'($urandom_range(0, 1));
            vecs[i] = model(v);
        end

        repeat (3) @(negedge clk);
        check_reset_values("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst_idle");

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a sweep, then the same sweep again.
        target = 143; chk_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("post_rst");
        run_vec(100, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
